fbw_row_sink: RTL and testbench
===============================

// Module: fbw_row_sink
// PURPOSE
//  Responder end of the frame-buffer write interface driven by a pattern/row generator.
//  Accepts per-column pixel writes into a double-buffered line buffer.
//  On row store, copies the completed line into the back frame in frame memory.
//  Manages double-buffered frames: front frame is read by the display, back frame is written.
//  Front/back exchange happens on a display vsync after the generator requests a frame swap.
// PARAMETERS
//  LOG_N_ROWS  6   log2 of panel rows; row address width
//  LOG_N_COLS  6   log2 of panel columns; column address width
//  BITDEPTH    24  pixel width in bits
// PORTS
//  clk            in   1                          system clock
//  rst            in   1                          reset, asynchronous, active-high
//  fbw_row_addr   in   LOG_N_ROWS                 target row for fbw_row_store
//  fbw_row_store  in   1                          copy current write line buffer to fbw_row_addr
//  fbw_row_rdy    out  1                          copy engine idle; store accepted only when high
//  fbw_row_swap   in   1                          toggle which line buffer receives fbw_wren writes
//  fbw_data       in   BITDEPTH                   pixel data
//  fbw_col_addr   in   LOG_N_COLS                 pixel column
//  fbw_wren       in   1                          write fbw_data at fbw_col_addr into write line buffer
//  frame_swap     in   1                          back frame complete; request front/back exchange
//  frame_rdy      out  1                          back frame free for writing
//  disp_vsync     in   1                          1-cycle pulse at display frame boundary
//  disp_frame_sel out  1                          frame index the display must read
//  fbm_addr       out  1+LOG_N_ROWS+LOG_N_COLS    frame memory address {frame, row, col}
//  fbm_data       out  BITDEPTH                   frame memory write data
//  fbm_wren       out  1                          frame memory write strobe
// BEHAVIOUR
//  Reset values (async):
//   fbw_row_rdy=1, frame_rdy=1, disp_frame_sel=0, fbm_wren=0, fbm_addr=0, fbm_data=0.
//   Write line buffer index lb_wr=0; swap_pending=0; copy FSM=IDLE.
//  Line buffers: two arrays of 2^LOG_N_COLS x BITDEPTH; registered read, 1-cycle latency.
//   fbw_wren writes buffer lb_wr at any time, including while the other buffer is being copied.
//   fbw_row_swap toggles lb_wr on the clock edge (ignored when fbw_row_rdy=0).
//  Copy FSM: IDLE -> COPY -> FLUSH -> IDLE.
//   IDLE: fbw_row_rdy=1. Store accepted when fbw_row_store=1 at edge T.
//    Latches row, source buffer = lb_wr (pre-toggle value if swap is in the same cycle),
//    and dst frame = ~disp_frame_sel. Goes to COPY.
//   COPY: issues reads col 0..2^LOG_N_COLS-1, one per cycle; on last col goes to FLUSH.
//   FLUSH: final write cycle; then IDLE.
//   fbm_wren=1 on cycles T+2 .. T+2^LOG_N_COLS+1 (one write per column, ascending).
//    fbm_addr={dst, row, col}.
//   fbw_row_rdy low from T+1 through T+2^LOG_N_COLS+1; high again at T+2^LOG_N_COLS+2.
//   fbw_row_store while fbw_row_rdy=0: ignored, no side effects.
//  Frame swap:
//   frame_swap=1 sets swap_pending, so frame_rdy=0 from next cycle. A repeat frame_swap while
//    pending is ignored.
//   Swap executes on disp_vsync=1 with (swap_pending or frame_swap) and copy FSM IDLE:
//    disp_frame_sel toggles, swap_pending clears, frame_rdy=1 next cycle.
//   frame_swap and disp_vsync in the same cycle (FSM IDLE): immediate swap; frame_rdy stays 1.
//   disp_vsync during a copy: swap deferred to a later vsync; the front frame never changes mid-copy.
//  Reset mid-copy: copy aborted, fbm_wren=0 immediately, partial row left in memory.
//  Widths: column and row counters wrap modulo 2^LOG_N; no arithmetic overflow paths.
// TESTING
//  1 Reset release -> fbw_row_rdy=1, frame_rdy=1, disp_frame_sel=0, fbm_wren=0.
//  2 Write cols 0..63 data=col, store+swap row 5 at T
//    -> 64 writes at T+2..T+65 to addr {1,5,col}, data=col; rdy high at T+66.
//  3 Fill other buffer with data=0xAA0000|col during test 2 copy
//    -> copy data unchanged; next store writes 0xAA00xx.
//  4 frame_swap, no vsync for 1000 cycles -> frame_rdy=0 throughout.
//    vsync pulse -> disp_frame_sel=1, frame_rdy=1; next copies target frame 0.
//  5 frame_swap and disp_vsync same cycle -> disp_frame_sel toggles, frame_rdy never 0.
//  6 Store while busy -> ignored (write count unchanged).
//    rst mid-copy -> fbm_wren=0 at once, fbw_row_rdy=1, disp_frame_sel=0.

Source files
------------

// File: rtl/fbw_row_sink_if.sv
// Frame-buffer write bus between the row generator (master) and the row sink (slave),
// including the display vsync input and the frame-memory write port.
interface fbw_row_sink_if #(
  parameter int LOG_N_ROWS = 6,
  parameter int LOG_N_COLS = 6,
  parameter int BITDEPTH   = 24
);
  logic [LOG_N_ROWS-1:0]            fbw_row_addr;
  logic                             fbw_row_store;
  logic                             fbw_row_rdy;
  logic                             fbw_row_swap;
  logic [BITDEPTH-1:0]              fbw_data;
  logic [LOG_N_COLS-1:0]            fbw_col_addr;
  logic                             fbw_wren;
  logic                             frame_swap;
  logic                             frame_rdy;
  logic                             disp_vsync;
  logic                             disp_frame_sel;
  logic [LOG_N_ROWS+LOG_N_COLS:0]   fbm_addr;
  logic [BITDEPTH-1:0]              fbm_data;
  logic                             fbm_wren;

  modport master (
    output fbw_row_addr, fbw_row_store, fbw_row_swap, fbw_data, fbw_col_addr, fbw_wren,
           frame_swap, disp_vsync,
    input  fbw_row_rdy, frame_rdy, disp_frame_sel, fbm_addr, fbm_data, fbm_wren
  );

  modport slave (
    input  fbw_row_addr, fbw_row_store, fbw_row_swap, fbw_data, fbw_col_addr, fbw_wren,
           frame_swap, disp_vsync,
    output fbw_row_rdy, frame_rdy, disp_frame_sel, fbm_addr, fbm_data, fbm_wren
  );
endinterface

// File: rtl/fbw_row_sink.sv
// Row sink: double-buffered line buffer, row copy engine into the back frame,
// and front/back frame exchange aligned to display vsync.
module fbw_row_sink #(
  parameter int LOG_N_ROWS = 6,
  parameter int LOG_N_COLS = 6,
  parameter int BITDEPTH   = 24
) (
  input logic clk,
  input logic rst,
  fbw_row_sink_if.slave bus
);
  localparam int N_COLS = 1 << LOG_N_COLS;

  typedef enum logic [1:0] {IDLE, COPY, FLUSH} state_t;

  typedef struct packed {
    logic                  src;
    logic                  dst;
    logic [LOG_N_ROWS-1:0] row;
  } job_t;

  state_t                         state, state_nxt;
  job_t                           job;
  logic [LOG_N_COLS-1:0]          col;
  logic                           lb_wr;
  logic                           swap_pending;
  logic                           frame_sel;
  logic                           row_rdy;
  logic                           rd_en;
  logic                           store_ok;
  logic                           swap_go;
  logic                           wren_q;
  logic [LOG_N_ROWS+LOG_N_COLS:0] addr_q;
  logic [BITDEPTH-1:0]            rd_data;
  logic [BITDEPTH-1:0]            lb0 [N_COLS];
  logic [BITDEPTH-1:0]            lb1 [N_COLS];

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.fbw_row_store) state_nxt = COPY;
      COPY:    if (col == '1) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    row_rdy = 1'b0;
    rd_en   = 1'b0;
    case (state)
      IDLE:    row_rdy = 1'b1;
      COPY:    rd_en   = 1'b1;
      default: ;
    endcase
  end

  assign store_ok = row_rdy & bus.fbw_row_store;
  // Never move the front frame while a row is landing in the back frame.
  assign swap_go  = bus.disp_vsync & (swap_pending | bus.frame_swap) & (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job          <= '0;
      col          <= '0;
      lb_wr        <= 1'b0;
      swap_pending <= 1'b0;
      frame_sel    <= 1'b0;
      wren_q       <= 1'b0;
      addr_q       <= '0;
      rd_data      <= '0;
    end else begin
      if (store_ok) begin
        job <= '{src: lb_wr, dst: ~frame_sel, row: bus.fbw_row_addr};
        col <= '0;
      end else if (rd_en) begin
        col <= col + 1'b1;
      end
      if (row_rdy && bus.fbw_row_swap) lb_wr <= ~lb_wr;
      if (swap_go) begin
        frame_sel    <= ~frame_sel;
        swap_pending <= 1'b0;
      end else if (bus.frame_swap) begin
        swap_pending <= 1'b1;
      end
      // Address travels with the registered buffer read so strobe, addr and data align.
      wren_q <= rd_en;
      if (rd_en) begin
        rd_data <= job.src ? lb1[col] : lb0[col];
        addr_q  <= {job.dst, job.row, col};
      end
    end
  end

  always_ff @(posedge clk)
    if (bus.fbw_wren) begin
      if (lb_wr) lb1[bus.fbw_col_addr] <= bus.fbw_data;
      else       lb0[bus.fbw_col_addr] <= bus.fbw_data;
    end

  assign bus.fbw_row_rdy    = row_rdy;
  assign bus.frame_rdy      = ~swap_pending;
  assign bus.disp_frame_sel = frame_sel;
  assign bus.fbm_addr       = addr_q;
  assign bus.fbm_data       = rd_data;
  assign bus.fbm_wren       = wren_q;
endmodule

// File: tb/tb_fbw_row_sink.sv
// Scenario bench for fbw_row_sink: line-buffer contents and frame selection are
// modelled as plain arrays/flags; frame-memory writes are captured and compared.
module tb_fbw_row_sink;
  localparam int R = 6, C = 6, BD = 24, NC = 64, HM = 16383;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fbw_row_sink_if #(.LOG_N_ROWS(R), .LOG_N_COLS(C), .BITDEPTH(BD)) bus();
  fbw_row_sink #(.LOG_N_ROWS(R), .LOG_N_COLS(C), .BITDEPTH(BD)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int cyc; logic [R+C:0] addr; logic [BD-1:0] data; } wr_t;
  wr_t  wq[$];
  int   cyc = 0;
  logic rdy_hist  [HM+1];
  logic frdy_hist [HM+1];
  logic sel_hist  [HM+1];

  int vectors = 0, miscompares = 0;

  // reference state
  logic [BD-1:0] m_lb [2][NC];
  logic          m_lbwr = 1'b0, m_sel = 1'b0;
  logic [BD-1:0] exp_data [NC];
  logic          exp_dst;
  logic [R-1:0]  exp_row;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rdy_hist[cyc & HM]  = bus.fbw_row_rdy;
    frdy_hist[cyc & HM] = bus.frame_rdy;
    sel_hist[cyc & HM]  = bus.disp_frame_sel;
    if (bus.fbm_wren === 1'b1) wq.push_back('{cyc, bus.fbm_addr, bus.fbm_data});
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // mode 0: data=col, 1: random, 3: 0xAA0000|col
  task automatic fill_buf(input int mode);
    logic [BD-1:0] d;
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      case (mode)
        0:       d = BD'(c);
        1:       d = BD'($urandom());
        default: d = 24'hAA0000 | BD'(c);
      endcase
      bus.fbw_wren = 1'b1; bus.fbw_col_addr = C'(c); bus.fbw_data = d;
      m_lb[m_lbwr][c] = d;
    end
    @(negedge clk);
    bus.fbw_wren = 1'b0;
  endtask

  task automatic issue_store(input logic [R-1:0] row, output int t);
    @(negedge clk);
    wq.delete();
    bus.fbw_row_addr = row; bus.fbw_row_store = 1'b1; bus.fbw_row_swap = 1'b1;
    t = cyc;
    exp_dst = ~m_sel; exp_row = row;
    for (int c = 0; c < NC; c++) exp_data[c] = m_lb[m_lbwr][c];
    m_lbwr = ~m_lbwr;
    @(negedge clk);
    bus.fbw_row_store = 1'b0; bus.fbw_row_swap = 1'b0;
  endtask

  task automatic test_reset;
    bus.fbw_row_addr = '0; bus.fbw_row_store = 0; bus.fbw_row_swap = 0; bus.fbw_data = '0;
    bus.fbw_col_addr = '0; bus.fbw_wren = 0; bus.frame_swap = 0; bus.disp_vsync = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.fbm_addr !== '0 || bus.fbm_data !== '0 || bus.fbm_wren !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_fbm: addr=%h data=%h wren=%b, required 0/0/0", bus.fbm_addr, bus.fbm_data, bus.fbm_wren);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.fbw_row_rdy, bus.frame_rdy, bus.disp_frame_sel, bus.fbm_wren} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_flags: rdy,frdy,sel,wren=%b%b%b%b, required 1100",
               bus.fbw_row_rdy, bus.frame_rdy, bus.disp_frame_sel, bus.fbm_wren);
    end
  endtask

  task automatic test_row_copy(input logic [R-1:0] row, input int mode, input bit fill_other);
    int t, lows;
    if (mode < 2) fill_buf(mode);
    issue_store(row, t);
    if (fill_other) fill_buf(3);
    wait_until(t + 67);
    vectors++;
    if (wq.size() !== NC) begin
      miscompares++;
      $display("FAIL copy_count row %0d: %0d writes, required %0d", row, wq.size(), NC);
    end
    for (int k = 0; k < wq.size() && k < NC; k++) begin
      vectors++;
      if (wq[k].cyc !== t + 2 + k || wq[k].addr !== {exp_dst, exp_row, C'(k)} || wq[k].data !== exp_data[k]) begin
        miscompares++;
        $display("FAIL copy_wr %0d: cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h", k,
                 wq[k].cyc - t, wq[k].addr, wq[k].data, 2 + k, {exp_dst, exp_row, C'(k)}, exp_data[k]);
      end
    end
    lows = 0;
    for (int i = 1; i <= 65; i++) if (rdy_hist[(t + i) & HM] === 1'b0) lows++;
    vectors++;
    if (lows !== 65 || rdy_hist[(t + 66) & HM] !== 1'b1) begin
      miscompares++;
      $display("FAIL copy_rdy: low for %0d cycles, rdy at T+66=%b, required 65 and 1", lows, rdy_hist[(t + 66) & HM]);
    end
  endtask

  task automatic test_frame_swap;
    int t, bad;
    @(negedge clk); bus.frame_swap = 1'b1; t = cyc;
    @(negedge clk); bus.frame_swap = 1'b0;
    repeat (500) @(negedge clk);
    bus.frame_swap = 1'b1;
    @(negedge clk); bus.frame_swap = 1'b0;
    wait_until(t + 1001);
    bad = 0;
    for (int i = 1; i <= 1000; i++)
      if (frdy_hist[(t + i) & HM] !== 1'b0 || sel_hist[(t + i) & HM] !== m_sel) bad++;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL swap_pending: %0d cycles with frame_rdy!=0 or sel moved, required 0", bad);
    end
    bus.disp_vsync = 1'b1;
    @(negedge clk); bus.disp_vsync = 1'b0;
    m_sel = ~m_sel;
    vectors++;
    if (bus.disp_frame_sel !== m_sel || bus.frame_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL swap_vsync: sel=%b frdy=%b, required sel=%b frdy=1", bus.disp_frame_sel, bus.frame_rdy, m_sel);
    end
    test_row_copy(6'($urandom_range(63, 0)), 1, 1'b0);
  endtask

  task automatic test_swap_vsync_same;
    int t, bad;
    @(negedge clk); bus.frame_swap = 1'b1; bus.disp_vsync = 1'b1; t = cyc;
    @(negedge clk); bus.frame_swap = 1'b0; bus.disp_vsync = 1'b0;
    m_sel = ~m_sel;
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i <= 3; i++) if (frdy_hist[(t + i) & HM] !== 1'b1) bad++;
    vectors++;
    if (bad !== 0 || bus.disp_frame_sel !== m_sel) begin
      miscompares++;
      $display("FAIL swap_same_cycle: %0d frame_rdy-low cycles, sel=%b, required 0 and sel=%b", bad, bus.disp_frame_sel, m_sel);
    end
  endtask

  task automatic test_vsync_during_copy;
    int t, bad;
    logic old_sel;
    old_sel = m_sel;
    issue_store(6'($urandom_range(63, 0)), t);
    @(negedge clk); bus.frame_swap = 1'b1;
    @(negedge clk); bus.frame_swap = 1'b0;
    wait_until(t + 10);
    bus.disp_vsync = 1'b1;
    @(negedge clk); bus.disp_vsync = 1'b0;
    wait_until(t + 67);
    bad = 0;
    for (int i = 0; i <= 66; i++) if (sel_hist[(t + i) & HM] !== old_sel) bad++;
    for (int k = 0; k < wq.size(); k++)
      if (wq[k].addr !== {exp_dst, exp_row, C'(k)} || wq[k].data !== exp_data[k]) bad++;
    vectors++;
    if (bad !== 0 || wq.size() !== NC || bus.frame_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL vsync_mid_copy: %0d bad cycles/writes, %0d writes, frdy=%b, required 0, %0d, 0",
               bad, wq.size(), bus.frame_rdy, NC);
    end
    bus.disp_vsync = 1'b1;
    @(negedge clk); bus.disp_vsync = 1'b0;
    m_sel = ~m_sel;
    vectors++;
    if (bus.disp_frame_sel !== m_sel || bus.frame_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL deferred_swap: sel=%b frdy=%b, required sel=%b frdy=1", bus.disp_frame_sel, bus.frame_rdy, m_sel);
    end
  endtask

  task automatic test_busy_store;
    int t, bad;
    logic [R-1:0] ra, rb;
    ra = 6'($urandom_range(63, 0));
    rb = ra ^ 6'h15;
    issue_store(ra, t);
    wait_until(t + 5);
    bus.fbw_row_addr = rb; bus.fbw_row_store = 1'b1; bus.fbw_row_swap = 1'b1;
    repeat (10) @(negedge clk);
    bus.fbw_row_store = 1'b0; bus.fbw_row_swap = 1'b0;
    wait_until(t + 67);
    bad = 0;
    for (int k = 0; k < wq.size(); k++) if (wq[k].addr !== {exp_dst, ra, C'(k)}) bad++;
    vectors++;
    if (wq.size() !== NC || bad !== 0 || rdy_hist[(t + 66) & HM] !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_store: %0d writes, %0d wrong row, rdy=%b, required %0d, 0, 1",
               wq.size(), bad, rdy_hist[(t + 66) & HM], NC);
    end
  endtask

  task automatic test_reset_mid_copy;
    int t;
    issue_store(6'($urandom_range(63, 0)), t);
    wait_until(t + 20);
    vectors++;
    if (bus.fbm_wren !== 1'b1 || bus.disp_frame_sel !== m_sel) begin
      miscompares++;
      $display("FAIL pre_reset: wren=%b sel=%b, required 1 and %b", bus.fbm_wren, bus.disp_frame_sel, m_sel);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.fbm_wren, bus.fbw_row_rdy, bus.disp_frame_sel, bus.frame_rdy} !== 4'b0101) begin
      miscompares++;
      $display("FAIL reset_mid_copy: wren,rdy,sel,frdy=%b%b%b%b, required 0101",
               bus.fbm_wren, bus.fbw_row_rdy, bus.disp_frame_sel, bus.frame_rdy);
    end
    @(negedge clk); rst = 1'b0;
    m_sel = 1'b0; m_lbwr = 1'b0;
    wq.delete();
    repeat (5) @(negedge clk);
    vectors++;
    if (wq.size() !== 0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: %0d writes after reset, required 0", wq.size());
    end
  endtask

  initial begin
    test_reset;
    test_row_copy(6'd5, 0, 1'b1);
    test_row_copy(6'($urandom_range(63, 0)), 2, 1'b0);
    test_row_copy(6'($urandom_range(63, 0)), 1, 1'b0);
    test_frame_swap;
    test_swap_vsync_same;
    test_vsync_during_copy;
    test_busy_store;
    test_row_copy(6'($urandom_range(63, 0)), 1, 1'b1);
    test_reset_mid_copy;
    test_row_copy(6'($urandom_range(63, 0)), 1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
